row_pixel_fetcher: RTL and testbench
====================================

# row_pixel_fetcher

Upstream feeder for the TLC5941 pixel driver. On a row request it reads one display row from the external frame-buffer RAM, expands each 8-bit colour component to a 12-bit grayscale word, and streams 48 word pairs (left and right column) in driver word order over a valid/ready interface. It owns address sequencing, RAM latency and backpressure, so the driver only shifts bits out.

## Interface
- `ROWS`, default 6: display rows; valid `row_sel` range is 0..ROWS-1.
- `pixel_clock`, input, 1: the only clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high. Clears all state.
- `row_start`, input, 1: single-cycle request to fetch the row selected by `row_sel`.
- `row_sel`, input, 3: row index, sampled when `row_start` is high.
- `fb_en`, output, 1: frame-buffer read enable.
- `fb_addr`, output, 7: read address `{row[2:0], col[3:0]}`.
- `fb_rdata`, input, 48: `{right R,G,B, left R,G,B}`, 8 bits each. Valid exactly 1 cycle after `fb_en`.
- `word_valid`, output, 1: output word pair available.
- `word_ready`, input, 1: consumer accepts the pair. A transfer occurs when `word_valid && word_ready`.
- `word_l`, output, 12: left-column grayscale word.
- `word_r`, output, 12: right-column grayscale word.
- `word_last`, output, 1: marks word 47 of the row.
- `busy`, output, 1: high from an accepted `row_start` until the word-47 transfer.
- `row_done`, output, 1: one-cycle pulse in the cycle after the word-47 transfer.
- `row_err`, output, 1: one-cycle pulse when `row_start` arrives with `row_sel >= ROWS`.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE → FETCH on `row_start` with a valid `row_sel`. This latches the row and clears the word index `w`.
  - `row_start` with an invalid `row_sel` pulses `row_err` and stays in IDLE.
  - `row_start` while `busy` is ignored, with no error.
- Word mapping, for `w` = 0..47:
  - colour = `w/16` (0 = R, 1 = G, 2 = B).
  - col = `w%16`.
  - `fb_addr = {row, col}`. Each pixel is read 3 times, once per colour.
- FETCH issues one read per cycle while `fifo_count + inflight < 4`, then increments `w`.
  - After issuing `w = 47` the FSM moves to DRAIN.
- Pipeline: address stage → RAM data stage → conversion register → 4-entry output FIFO.
  - `inflight` counts reads issued but not yet written to the FIFO (0..2).
  - The colour tag travels with the data through the pipeline.
- DRAIN → IDLE on the transfer of the pair with `word_last`. `row_done` pulses in the next cycle.
- Conversion is per side and uses the selected 8-bit component `x`; see Configuration. Result is always 12 bits.
- FIFO:
  - Never overflows, because the issue rule guarantees it.
  - When empty, `word_valid = 0`.
  - Simultaneous push and pop keep the count unchanged.
- The FIFO is first-word-fall-through: `word_l`, `word_r` and `word_last` are driven from the head entry. They hold stable while `word_valid && !word_ready`.
- Reset mid-row discards the row. No `row_done` is produced.
- Reset values of outputs:
  - `fb_en = 0`, `fb_addr = 0`.
  - `word_valid = 0`, `word_l = 0`, `word_r = 0`, `word_last = 0`.
  - `busy = 0`, `row_done = 0`, `row_err = 0`.

## Timing
- `row_start` sampled at edge N.
- N+1: `fb_en = 1`, `fb_addr` = first address.
- N+2: `fb_rdata` valid.
- N+3: conversion registered.
- N+4: `word_valid = 1`, showing word 0.
- Throughput: 1 pair per cycle with `word_ready` held high. A full row takes 48 transfers; `row_done` occurs at N+52 when never stalled.
- The `word_ready` to `word_valid` path is registered only; there are no combinational paths from inputs to outputs.
- `busy` rises at N+1 and falls together with the `row_done` pulse.

## Configuration
- `GAMMA_EN` defined: `word = (x*x) >> 4`, using a 16-bit product. Examples: 0xFF → 0xFE0, 0x80 → 0x400, 0x00 → 0x000.
- `GAMMA_EN` not defined: linear bit replication, `word = {x, x[7:4]}`. Examples: 0xFF → 0xFFF, 0x80 → 0x808.
- Latency is identical in both builds. The conversion register stage is always present.

## Test plan
- Basic row: RAM row 2 holds left R = 0xFF and right B = 0x80 at col 0, zero elsewhere. Pulse `row_start` with `row_sel = 2` and hold `word_ready = 1`. Expect:
  - First `word_valid` at N+4.
  - Pair 0: `word_l = 0xFE0` with `GAMMA_EN` (0xFFF without), `word_r = 0`.
  - Pair 32: `word_r = 0x400` with `GAMMA_EN` (0x808 without).
  - `word_last` on pair 47 and `row_done` at N+52.
- Address order: expect `fb_addr` sequence 0x20..0x2F repeated exactly 3 times, for 48 `fb_en` cycles total.
- Backpressure: toggle `word_ready` with the pattern 1,0,0,1. Expect:
  - Outputs hold stable while stalled.
  - No word lost or duplicated; 48 transfers in order.
  - FIFO count never exceeds 4.
- Bad or overlapping requests:
  - `row_sel = 6` → `row_err` pulse, `busy` stays 0.
  - `row_start` while busy → ignored; the current row completes unchanged.
- Reset mid-row: assert `reset` after 20 transfers. Expect all outputs back to reset values asynchronously and no `row_done`. A new `row_start` then produces a full row starting again at word 0.

Source files
------------

// File: rtl/row_pixel_fetcher.sv
// row_pixel_fetcher: reads one display row from the frame-buffer RAM, expands
// each 8-bit colour component to a 12-bit grayscale word and streams 48
// left/right word pairs to the TLC5941 shifter over valid/ready.
// Build option: define GAMMA_EN to use the squared (gamma) curve instead of
// linear bit replication. Latency is the same either way.

// Per-side conversion lane: picks the colour component named by the tag,
// converts it, and registers the result when the RAM data stage is valid.
module row_pixel_fetcher_lane #(
    parameter int VEC_W = 12
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic             load,
    input  logic [1:0]       color,
    input  logic [23:0]      rgb,
    output logic [VEC_W-1:0] word
);
    logic [7:0]       x;
    logic [VEC_W-1:0] conv;

    // Component select: R sits in the top byte of each side's 24 bits.
    always_comb begin
        unique case (color)
            2'd0:    x = rgb[23:16];
            2'd1:    x = rgb[15:8];
            default: x = rgb[7:0];
        endcase
    end

`ifdef GAMMA_EN
    logic [15:0] sq;
    assign sq   = {8'd0, x} * {8'd0, x};
    assign conv = VEC_W'(sq >> 4);
`else
    assign conv = {x, x[7:4]};
`endif

    // Conversion register stage, present in both builds.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset)     word <= '0;
        else if (load) word <= conv;
    end
endmodule

module row_pixel_fetcher #(
    parameter int ROWS = 6
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        row_start,
    input  logic [2:0]  row_sel,
    output logic        fb_en,
    output logic [6:0]  fb_addr,
    input  logic [47:0] fb_rdata,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [11:0] word_l,
    output logic [11:0] word_r,
    output logic        word_last,
    output logic        busy,
    output logic        row_done,
    output logic        row_err
);
    localparam int NUM_LANES = 2;   // lane 0 = left column, lane 1 = right
    localparam int VEC_W     = 12;
    localparam int STAGES    = 2;   // RAM data stage, conversion register
    localparam int DEPTH     = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef struct packed {
        logic [NUM_LANES-1:0][VEC_W-1:0] word;
        logic                            last;
    } pair_t;

    logic [1:0]  state;
    logic [2:0]  row_q;
    logic [5:0]  w;
    logic        req_ok;
    logic        issue;
    logic [1:0]  inflight;

    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] last_pipe;
    logic [1:0]      color_d;
    logic [NUM_LANES-1:0][VEC_W-1:0] conv_word;

    pair_t       fifo_mem [DEPTH];
    pair_t       head;
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_cnt;
    logic        push;
    logic        pop;

    assign req_ok = ({29'd0, row_sel} < 32'(ROWS));

    // Reads issued but not yet in the FIFO: data stage + conversion stage.
    // Counting them against free FIFO space means the FIFO can never overflow,
    // and with a consumer that never stalls the sum settles at 3, so a read
    // goes out every cycle.
    assign inflight = 2'(vld_pipe[1]) + 2'(vld_pipe[2]);
    assign issue    = (state == FETCH) && ((4'(fifo_cnt) + 4'(inflight)) < 4'd4);

    // The read port is driven straight from registered state (no input paths).
    assign fb_en   = issue;
    assign fb_addr = issue ? {row_q, w[3:0]} : 7'd0;

    // Row FSM: latch row, walk w = 0..47, wait for the last pair to leave.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            row_q <= '0;
            w     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (row_start && req_ok) begin
                        state <= FETCH;
                        row_q <= row_sel;
                        w     <= '0;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        w <= w + 6'd1;
                        if (w == 6'd47) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head.last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid/last shift register and colour tag riding along with each read.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            color_d   <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], issue};
            last_pipe <= {last_pipe[STAGES-1:1], issue && (w == 6'd47)};
            color_d   <= w[5:4];
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        row_pixel_fetcher_lane #(
            .VEC_W(VEC_W)
        ) u_lane (
            .pixel_clock(pixel_clock),
            .reset      (reset),
            .load       (vld_pipe[1]),
            .color      (color_d),
            .rgb        (fb_rdata[24*i +: 24]),
            .word       (conv_word[i])
        );
    end

    assign push = vld_pipe[STAGES];
    assign pop  = (fifo_cnt != 3'd0) && word_ready;
    assign head = fifo_mem[rd_ptr];

    // Output FIFO storage and pointers; push and pop together leave the count alone.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{word: conv_word, last: last_pipe[STAGES]};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Fall-through head; zeroed when empty so idle outputs match reset.
    assign word_valid = (fifo_cnt != 3'd0);
    assign word_l     = word_valid ? head.word[0] : '0;
    assign word_r     = word_valid ? head.word[1] : '0;
    assign word_last  = word_valid && head.last;
    assign busy       = (state != IDLE);

    // Status pulses: done after the last transfer, error on a bad idle request.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            row_done <= 1'b0;
            row_err  <= 1'b0;
        end else begin
            row_done <= (state == DRAIN) && pop && head.last;
            row_err  <= row_start && (state == IDLE) && !req_ok;
        end
    end
endmodule

// File: tb/tb_row_pixel_fetcher.sv
// Bench for row_pixel_fetcher: conversion table, basic row timing, address
// order, backpressure, bad/overlapping requests, reset mid-row and random rows
// checked against an arithmetic reference model. Follows GAMMA_EN like the RTL.
module tb_row_pixel_fetcher;
    logic        pixel_clock = 1'b0;
    logic        reset = 1'b0;
    logic        row_start = 1'b0;
    logic [2:0]  row_sel = 3'd0;
    logic        fb_en;
    logic [6:0]  fb_addr;
    logic [47:0] fb_rdata = 48'd0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [11:0] word_l, word_r;
    logic        word_last, busy, row_done, row_err;

    row_pixel_fetcher #(.ROWS(6)) dut (
        .pixel_clock(pixel_clock), .reset(reset), .row_start(row_start),
        .row_sel(row_sel), .fb_en(fb_en), .fb_addr(fb_addr),
        .fb_rdata(fb_rdata), .word_valid(word_valid), .word_ready(word_ready),
        .word_l(word_l), .word_r(word_r), .word_last(word_last),
        .busy(busy), .row_done(row_done), .row_err(row_err)
    );

    always #5 pixel_clock = ~pixel_clock;

    logic [47:0] mem [0:127];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { logic [11:0] l; logic [11:0] r; logic last; } pair_t;
    typedef struct { logic [7:0] xl; logic [7:0] xr; logic [11:0] el; logic [11:0] er; } vec_t;

    pair_t got[$];
    int    addr_log[$];
    int    done_cyc[$];
    int    err_cyc[$];
    int    first_valid, first_fben, busy_rise, busy_fall, fifo_max;
    logic  busy_prev = 1'b0;
    logic  stall_prev = 1'b0;
    logic [25:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference conversion from the stated formulas, plain arithmetic.
    function automatic logic [11:0] conv(input logic [7:0] x);
        int v;
`ifdef GAMMA_EN
        v = (int'(x) * int'(x)) / 16;
`else
        v = int'(x) * 16 + int'(x) / 16;
`endif
        return 12'(v);
    endfunction

    // side 0 = left, 1 = right; color 0 = R, 1 = G, 2 = B
    function automatic logic [7:0] comp(input logic [47:0] d, input int side, input int color);
        logic [47:0] t;
        t = d >> (24 * side + 8 * (2 - color));
        return t[7:0];
    endfunction

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return $urandom_range(0, 3) != 0;
    endfunction

    // RAM model: data one cycle after the read enable.
    initial forever begin
        @(posedge pixel_clock);
        if (fb_en) fb_rdata <= mem[fb_addr];
    end

    initial forever begin
        @(posedge pixel_clock);
        cyc++;
    end

    // Monitor on the falling edge, away from the active edge.
    initial forever begin
        @(negedge pixel_clock);
        if (reset) begin
            stall_prev = 1'b0;
            busy_prev  = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold_while_stalled", {word_valid, word_l, word_r, word_last}, held);
            stall_prev = word_valid && !word_ready;
            held       = {word_valid, word_l, word_r, word_last};
            if (fb_en) begin
                if (first_fben < 0) first_fben = cyc;
                addr_log.push_back(int'(fb_addr));
            end
            if (word_valid && first_valid < 0) first_valid = cyc;
            if (word_valid && word_ready) got.push_back('{word_l, word_r, word_last});
            if (row_done) done_cyc.push_back(cyc);
            if (row_err) err_cyc.push_back(cyc);
            if (busy && !busy_prev && busy_rise < 0) busy_rise = cyc;
            if (!busy && busy_prev) busy_fall = cyc;
            busy_prev = busy;
            if (int'(dut.fifo_cnt) > fifo_max) fifo_max = int'(dut.fifo_cnt);
        end
    end

    task automatic clear_logs();
        got.delete(); addr_log.delete(); done_cyc.delete(); err_cyc.delete();
        first_valid = -1; first_fben = -1; busy_rise = -1; busy_fall = -1; fifo_max = 0;
    endtask

    // Request one row and run until row_done plus a short tail (bounded).
    task automatic run_row(input logic [2:0] sel, input int mode, input bit intr,
                           input logic [2:0] intr_sel, output int start);
        int k, tail;
        bit fin;
        clear_logs();
        @(posedge pixel_clock); #1;
        row_start = 1'b1; row_sel = sel; start = cyc; word_ready = rdy(mode, 0);
        k = 1; tail = 0; fin = 1'b0;
        while (!fin && k < 600) begin
            @(posedge pixel_clock); #1;
            row_start = 1'b0;
            if (intr && k == 12) begin row_start = 1'b1; row_sel = intr_sel; end
            word_ready = rdy(mode, k);
            if (done_cyc.size() > 0) tail++;
            if (tail > 4) fin = 1'b1;
            k++;
        end
        word_ready = 1'b0;
        chk("row_finished_in_budget", 64'(fin), 64'd1);
    endtask

    // Compare captured pairs and addresses against the reference model.
    task automatic check_row(input logic [2:0] sel, input string tag);
        logic [47:0] d;
        logic [11:0] el, er;
        chk({tag, "_pair_count"}, got.size(), 48);
        chk({tag, "_addr_count"}, addr_log.size(), 48);
        chk({tag, "_done_count"}, done_cyc.size(), 1);
        for (int i = 0; i < 48; i++) begin
            d  = mem[int'(sel) * 16 + i % 16];
            el = conv(comp(d, 0, i / 16));
            er = conv(comp(d, 1, i / 16));
            if (i < got.size())
                chk($sformatf("%s_pair%0d", tag, i), {got[i].l, got[i].r, got[i].last}, {el, er, (i == 47)});
            if (i < addr_log.size())
                chk($sformatf("%s_addr%0d", tag, i), addr_log[i], int'(sel) * 16 + i % 16);
        end
    endtask

    vec_t tbl[8];
    int   start, k;

    initial begin
`ifdef GAMMA_EN
        tbl[0] = '{8'hFF, 8'h80, 12'hFE0, 12'h400};
        tbl[1] = '{8'h80, 8'h00, 12'h400, 12'h000};
        tbl[2] = '{8'h00, 8'hFF, 12'h000, 12'hFE0};
        tbl[3] = '{8'h01, 8'h10, 12'h000, 12'h010};
        tbl[4] = '{8'h40, 8'hC3, 12'h100, 12'h948};
        tbl[5] = '{8'h7F, 8'h0F, 12'h3F0, 12'h00E};
        tbl[6] = '{8'hAA, 8'h01, 12'h70E, 12'h000};
        tbl[7] = '{8'h10, 8'h40, 12'h010, 12'h100};
`else
        tbl[0] = '{8'hFF, 8'h80, 12'hFFF, 12'h808};
        tbl[1] = '{8'h80, 8'h00, 12'h808, 12'h000};
        tbl[2] = '{8'h00, 8'hFF, 12'h000, 12'hFFF};
        tbl[3] = '{8'h01, 8'h10, 12'h010, 12'h101};
        tbl[4] = '{8'h40, 8'hC3, 12'h404, 12'hC3C};
        tbl[5] = '{8'h7F, 8'h0F, 12'h7F7, 12'h0F0};
        tbl[6] = '{8'hAA, 8'h01, 12'hAAA, 12'h010};
        tbl[7] = '{8'h10, 8'h40, 12'h101, 12'h404};
`endif
        for (int i = 0; i < 128; i++) mem[i] = 48'd0;
        clear_logs();

        // Reset state (asynchronous)
        #1 reset = 1'b1;
        #2;
        chk("reset_outputs", {fb_en, fb_addr, word_valid, word_l, word_r, word_last, busy, row_done, row_err}, 64'd0);
        repeat (2) @(posedge pixel_clock);
        #1 reset = 1'b0;

        // Basic row 2: left R = 0xFF, right B = 0x80 at col 0
        mem[32] = {8'h00, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h00};
        run_row(3'd2, 0, 1'b0, 3'd0, start);
        chk("first_fb_en_cycle", first_fben, start + 1);
        chk("busy_rise_cycle", busy_rise, start + 1);
        chk("first_valid_cycle", first_valid, start + 4);
        chk("pair0", got.size() > 0 ? {got[0].l, got[0].r} : 24'hxxxxxx, {tbl[0].el, 12'h000});
        chk("pair32_r", got.size() > 32 ? got[32].r : 12'hxxx, tbl[0].er);
        chk("row_done_cycle", done_cyc.size() > 0 ? done_cyc[0] : -1, start + 52);
        chk("busy_fall_cycle", busy_fall, start + 52);
        check_row(3'd2, "basic");

        // Conversion table on row 1, with the 1,0,0,1 backpressure pattern
        for (int i = 0; i < 8; i++) mem[16 + i] = {8'h00, 8'h00, tbl[i].xr, tbl[i].xl, 8'h00, 8'h00};
        run_row(3'd1, 1, 1'b0, 3'd0, start);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("table%0d_l", i), got.size() > i ? got[i].l : 12'hxxx, tbl[i].el);
            chk($sformatf("table%0d_r", i), got.size() > 32 + i ? got[32 + i].r : 12'hxxx, tbl[i].er);
        end
        check_row(3'd1, "backpressure");
        chk("fifo_max_le_4", 64'(fifo_max <= 4), 64'd1);

        // Invalid row requests while idle
        for (int s = 6; s < 8; s++) begin
            clear_logs();
            @(posedge pixel_clock); #1;
            row_start = 1'b1; row_sel = 3'(s); start = cyc;
            @(posedge pixel_clock); #1;
            row_start = 1'b0;
            repeat (6) @(posedge pixel_clock);
            #1;
            chk($sformatf("bad%0d_err_count", s), err_cyc.size(), 1);
            chk($sformatf("bad%0d_err_cycle", s), err_cyc.size() > 0 ? err_cyc[0] : -1, start + 1);
            chk($sformatf("bad%0d_busy_low", s), 64'(busy_rise < 0), 64'd1);
            chk($sformatf("bad%0d_no_reads", s), addr_log.size(), 0);
        end

        // Random frame buffer; rows with overlapping requests and random ready
        for (int i = 0; i < 128; i++) mem[i] = 48'({$urandom(), $urandom()});
        run_row(3'd4, 0, 1'b1, 3'd0, start);
        check_row(3'd4, "overlap_valid");
        chk("overlap_valid_no_err", err_cyc.size(), 0);
        run_row(3'd5, 1, 1'b1, 3'd7, start);
        check_row(3'd5, "overlap_bad");
        chk("overlap_bad_no_err", err_cyc.size(), 0);
        for (int it = 0; it < 6; it++) begin
            logic [2:0] rs;
            rs = 3'($urandom_range(0, 5));
            run_row(rs, 2, it[0], 3'($urandom_range(0, 7)), start);
            check_row(rs, $sformatf("rand%0d", it));
            chk($sformatf("rand%0d_no_err", it), err_cyc.size(), 0);
        end
        chk("fifo_max_random", 64'(fifo_max <= 4), 64'd1);

        // Reset after 20 transfers
        clear_logs();
        @(posedge pixel_clock); #1;
        row_start = 1'b1; row_sel = 3'd3; word_ready = 1'b1;
        @(posedge pixel_clock); #1;
        row_start = 1'b0;
        k = 0;
        while (got.size() < 20 && k < 200) begin
            @(posedge pixel_clock); #1;
            k++;
        end
        chk("reached_20_transfers", got.size(), 20);
        #2 reset = 1'b1;
        #1;
        chk("midrow_reset_outputs", {fb_en, fb_addr, word_valid, word_l, word_r, word_last, busy, row_done, row_err}, 64'd0);
        repeat (3) @(posedge pixel_clock);
        #1 reset = 1'b0;
        repeat (60) @(posedge pixel_clock);
        #1;
        chk("midrow_no_row_done", done_cyc.size(), 0);
        chk("midrow_no_more_transfers", got.size(), 20);
        word_ready = 1'b0;
        run_row(3'd3, 0, 1'b0, 3'd0, start);
        check_row(3'd3, "after_reset");
        chk("after_reset_first_valid", first_valid, start + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog_timeout actual=%0d expected=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule
